// File: rtl/pipelined_cla_adder.sv
// Pipelined N-bit carry-lookahead add/subtract, one SEG-bit segment per stage.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_cla_adder #(
    parameter int N   = 32,
    parameter int SEG = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
`ifdef CLA_OVF_EN
    output logic         ovf,
`endif
    output logic         cout
);
    localparam int STAGES = N / SEG;

    if (N % SEG != 0) begin : g_bad_cfg
        $error("N must be a multiple of SEG");
    end

    // returns {carry into msb, carry out, sum}
    function automatic logic [SEG+1:0] cla_seg(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG:0]   c;
        logic           t;
        logic           pp;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            t  = 1'b0;
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & ci);
        end
        return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic [N-1:0]   a_q [STAGES];
    logic [N-1:0]   b_q [STAGES];
    logic [N-1:0]   s_q [STAGES];
    logic           c_q [STAGES];
    logic           v_q [STAGES];
    logic [SEG+1:0] seg [STAGES];
    logic [N-1:0]   b_eff;
    logic           c0;
    logic           adv;

    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;
    assign adv      = !v_q[STAGES-1] | out_ready;
    assign in_ready = adv;

    // stage k sees its operand segment after k skew registers
    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign seg[k] = cla_seg(a[SEG-1:0], b_eff[SEG-1:0], c0);
        end else begin : g_rest
            assign seg[k] = cla_seg(a_q[k-1][k*SEG +: SEG],
                                    b_q[k-1][k*SEG +: SEG],
                                    c_q[k-1]);
        end
    end

`ifdef CLA_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
`ifdef CLA_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (adv) begin
            v_q[0] <= in_valid;
            a_q[0] <= a;
            b_q[0] <= b_eff;
            c_q[0] <= seg[0][SEG];
            s_q[0] <= N'(seg[0][SEG-1:0]);
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
                c_q[k] <= seg[k][SEG];
                s_q[k] <= s_q[k-1];
                s_q[k][k*SEG +: SEG] <= seg[k][SEG-1:0];
            end
`ifdef CLA_OVF_EN
            ovf_q <= seg[STAGES-1][SEG+1] ^ seg[STAGES-1][SEG];
`endif
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
`ifdef CLA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
